add_arbiter: RTL and testbench

Shares one 32-bit ripple-carry adder (ADDER32) between NREQ independent requesters. Each requester presents two operands and a carry-in over a valid/ready handshake. The block picks one requester round-robin, sequences the operation through the adder, and returns a registered sum, carry-out and requester ID on a valid/ready response port. It sits between the issue logic and the single shared adder, so no requester ever drives the adder directly.

---
 rtl/add_arbiter_pkg.sv | 15 +
 rtl/add_arbiter_adder32.sv | 22 ++
 rtl/add_arbiter_rr_pick.sv | 26 ++
 rtl/add_arbiter.sv | 171 +++++++++++++++++
 tb/tb_add_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
// ADDARB_WIDE_EN (when defined) enables the two-pass 64-bit add.
package add_arbiter_pkg;

  localparam int ADD_W    = 32;
  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_EXEC_HI = 2'd2
  } state_t;

endpackage

// File: rtl/add_arbiter_adder32.sv
// 32-bit ripple-carry adder shared by all requesters.
// Purely combinational; no flow control of its own.
module ADDER32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [32:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 32; g++) begin : g_fa
    assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
    assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_c[32];

endmodule

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after last+1.
// Zero latency; o_any_valid low means o_grant is don't-care (driven 0).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_last,
  output logic [IDW-1:0]  o_grant,
  output logic            o_any_valid
);

  always_comb begin
    o_grant     = '0;
    o_any_valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(i_last) + k) % NREQ;
      if (!o_any_valid && i_valid[idx]) begin
        o_grant     = IDW'(idx);
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one ADDER32 among NREQ requesters; narrow result 2 cycles after accept.
// ADDARB_WIDE_EN adds a 64-bit op via EXEC_HI (3 cycles). No accept while the response is stalled.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*ADD_W-1:0] i_req_a,
  input  logic [NREQ*ADD_W-1:0] i_req_b,
  input  logic [NREQ-1:0]       i_req_cin,
`ifdef ADDARB_WIDE_EN
  input  logic [NREQ-1:0]       i_req_wide,
  input  logic [NREQ*ADD_W-1:0] i_req_a_hi,
  input  logic [NREQ*ADD_W-1:0] i_req_b_hi,
  output logic [ADD_W-1:0]      o_rsp_sum_hi,
`endif
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [IDW-1:0]        o_rsp_id,
  output logic [ADD_W-1:0]      o_rsp_sum,
  output logic                  o_rsp_cout
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("add_arbiter: NREQ out of range");
  end

  state_t           r_state;
  logic [IDW-1:0]   r_last;
  logic [ADD_W-1:0] r_a, r_b;
  logic             r_cin;
  logic [IDW-1:0]   r_id;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [ADD_W-1:0] r_rsp_sum;
  logic             r_rsp_cout;

  logic [ADD_W-1:0] w_a_arr [NREQ];
  logic [ADD_W-1:0] w_b_arr [NREQ];
  logic [IDW-1:0]   w_grant;
  logic             w_any;
  logic             w_accept;
  logic [ADD_W-1:0] w_add_a, w_add_b, w_sum;
  logic             w_add_cin, w_cout;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a_arr[g] = i_req_a[g*ADD_W +: ADD_W];
    assign w_b_arr[g] = i_req_b[g*ADD_W +: ADD_W];
  end

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .i_valid     (i_req_valid),
    .i_last      (r_last),
    .o_grant     (w_grant),
    .o_any_valid (w_any)
  );

  // Response slot is reusable when empty or being drained this cycle.
  assign w_accept    = i_rst_n && (r_state == ST_IDLE) && w_any &&
                       (!r_rsp_valid || i_rsp_ready);
  assign o_req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;

`ifdef ADDARB_WIDE_EN
  logic [ADD_W-1:0] w_ahi_arr [NREQ];
  logic [ADD_W-1:0] w_bhi_arr [NREQ];
  logic [ADD_W-1:0] r_a_hi, r_b_hi, r_rsp_sum_hi;
  logic             r_wide, r_carry;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack_hi
    assign w_ahi_arr[g] = i_req_a_hi[g*ADD_W +: ADD_W];
    assign w_bhi_arr[g] = i_req_b_hi[g*ADD_W +: ADD_W];
  end

  assign w_add_a      = (r_state == ST_EXEC_HI) ? r_a_hi  : r_a;
  assign w_add_b      = (r_state == ST_EXEC_HI) ? r_b_hi  : r_b;
  assign w_add_cin    = (r_state == ST_EXEC_HI) ? r_carry : r_cin;
  assign o_rsp_sum_hi = r_rsp_sum_hi;
`else
  assign w_add_a   = r_a;
  assign w_add_b   = r_b;
  assign w_add_cin = r_cin;
`endif

  ADDER32 u_add (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IDW'(NREQ - 1);
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
`ifdef ADDARB_WIDE_EN
      r_a_hi       <= '0;
      r_b_hi       <= '0;
      r_wide       <= 1'b0;
      r_carry      <= 1'b0;
      r_rsp_sum_hi <= '0;
`endif
    end else begin
      if (r_rsp_valid && i_rsp_ready) r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= w_a_arr[w_grant];
            r_b     <= w_b_arr[w_grant];
            r_cin   <= i_req_cin[w_grant];
            r_id    <= w_grant;
            r_last  <= w_grant;
            r_state <= ST_EXEC;
`ifdef ADDARB_WIDE_EN
            r_a_hi  <= w_ahi_arr[w_grant];
            r_b_hi  <= w_bhi_arr[w_grant];
            r_wide  <= i_req_wide[w_grant];
`endif
          end
        end
        ST_EXEC: begin
          r_rsp_sum <= w_sum;
          r_rsp_id  <= r_id;
`ifdef ADDARB_WIDE_EN
          if (r_wide) begin
            r_carry <= w_cout;
            r_state <= ST_EXEC_HI;
          end else begin
            r_rsp_sum_hi <= '0;
            r_rsp_cout   <= w_cout;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_IDLE;
          end
`else
          r_rsp_cout  <= w_cout;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_IDLE;
`endif
        end
`ifdef ADDARB_WIDE_EN
        ST_EXEC_HI: begin
          r_rsp_sum_hi <= w_sum;
          r_rsp_cout   <= w_cout;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter (NREQ=4).
module tb_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]  req_cin;
  logic             rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0]   rsp_id;
  logic [31:0]      rsp_sum;
`ifdef ADDARB_WIDE_EN
  logic [NREQ-1:0]    req_wide;
  logic [NREQ*32-1:0] req_a_hi, req_b_hi;
  logic [31:0]        rsp_sum_hi;
`endif

  int checks = 0;
  int errors = 0;

  add_arbiter #(.NREQ(NREQ)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_cin    (req_cin),
`ifdef ADDARB_WIDE_EN
    .i_req_wide   (req_wide),
    .i_req_a_hi   (req_a_hi),
    .i_req_b_hi   (req_b_hi),
    .o_rsp_sum_hi (rsp_sum_hi),
`endif
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_sum    (rsp_sum),
    .o_rsp_cout   (rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin operands: a=0x11111111*(i+1), b=i+1, cin=i[0]
  logic [31:0] rr_sum [NREQ];
  logic [IDW-1:0] order [5];

  initial begin
    rr_sum[0] = 32'h1111_1112;
    rr_sum[1] = 32'h2222_2225;
    rr_sum[2] = 32'h3333_3336;
    rr_sum[3] = 32'h4444_4449;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
`ifdef ADDARB_WIDE_EN
    req_wide = '0; req_a_hi = '0; req_b_hi = '0;
`endif
    tick(); tick();
    chk("ready_in_reset", 64'(req_ready), 64'h0);
    req_valid = '0;
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'h0);
    chk("rst_id",    64'(rsp_id),    64'h0);
    chk("rst_sum",   64'(rsp_sum),   64'h0);
    chk("rst_cout",  64'(rsp_cout),  64'h0);
`ifdef ADDARB_WIDE_EN
    chk("rst_sum_hi", 64'(rsp_sum_hi), 64'h0);
`endif

    // Narrow op with carry-in on requester 2
    req_a[64 +: 32] = 32'h5; req_b[64 +: 32] = 32'h7; req_cin[2] = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("n1_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    #1;
    chk("n1_exec_valid", 64'(rsp_valid), 64'h0);
    chk("n1_exec_ready", 64'(req_ready), 64'h0);
    tick();
    chk("n1_valid", 64'(rsp_valid), 64'h1);
    chk("n1_id",    64'(rsp_id),    64'h2);
    chk("n1_sum",   64'(rsp_sum),   64'hD);
    chk("n1_cout",  64'(rsp_cout),  64'h0);

    // Wrap-around on requester 1, accepted in the same cycle as the drain
    req_a[32 +: 32] = 32'hFFFF_FFFF; req_b[32 +: 32] = 32'h1; req_cin[1] = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    #1;
    chk("wrap_drained", 64'(rsp_valid), 64'h0);
    tick();
    chk("wrap_valid", 64'(rsp_valid), 64'h1);
    chk("wrap_id",    64'(rsp_id),    64'h1);
    chk("wrap_sum",   64'(rsp_sum),   64'h0);
    chk("wrap_cout",  64'(rsp_cout),  64'h1);

    // Reset during EXEC abandons requester 3's op
    req_valid = 4'b1000;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    chk("midrst_valid0", 64'(rsp_valid), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_valid1", 64'(rsp_valid), 64'h0);
    chk("midrst_sum",    64'(rsp_sum),   64'h0);
    tick();
    chk("midrst_valid2", 64'(rsp_valid), 64'h0);

    // Round-robin with all requesters valid
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = 32'h1111_1111 * (i + 1);
      req_b[i*32 +: 32] = 32'(i + 1);
      req_cin[i] = i[0];
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << order[n]));
      tick();
      chk("rr_exec_ready", 64'(req_ready), 64'h0);
      tick();
      chk("rr_valid", 64'(rsp_valid), 64'h1);
      chk("rr_id",    64'(rsp_id),    64'(order[n]));
      chk("rr_sum",   64'(rsp_sum),   64'(rr_sum[order[n]]));
    end

    // Backpressure on requester 0's result
    rsp_ready = 1'b0;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk("bp_ready", 64'(req_ready), 64'h0);
      chk("bp_valid", 64'(rsp_valid), 64'h1);
      chk("bp_id",    64'(rsp_id),    64'h0);
      chk("bp_sum",   64'(rsp_sum),   64'h1111_1112);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(req_ready), 64'h2);
    tick();
    chk("bp_drained", 64'(rsp_valid), 64'h0);
    tick();
    chk("bp_next_valid", 64'(rsp_valid), 64'h1);
    chk("bp_next_id",    64'(rsp_id),    64'h1);
    chk("bp_next_sum",   64'(rsp_sum),   64'h2222_2225);

`ifdef ADDARB_WIDE_EN
    // 64-bit op on requester 2: {1,FFFFFFFF} + {0,1}
    req_valid = 4'b0100;
    req_wide[2] = 1'b1;
    req_a[64 +: 32] = 32'hFFFF_FFFF; req_a_hi[64 +: 32] = 32'h1;
    req_b[64 +: 32] = 32'h1;         req_b_hi[64 +: 32] = 32'h0;
    req_cin[2] = 1'b0;
    #1;
    chk("wide_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    tick();
    chk("wide_t2_valid", 64'(rsp_valid), 64'h0);
    tick();
    chk("wide_valid",  64'(rsp_valid),  64'h1);
    chk("wide_id",     64'(rsp_id),     64'h2);
    chk("wide_sum",    64'(rsp_sum),    64'h0);
    chk("wide_sum_hi", 64'(rsp_sum_hi), 64'h2);
    chk("wide_cout",   64'(rsp_cout),   64'h0);
`endif

    req_valid = '0;
    tick();
    chk("end_valid", 64'(rsp_valid), 64'h0);
    chk("end_ready", 64'(req_ready), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
